uart_tx_fifo_cfg: RTL and testbench
===================================

Name: uart_tx_fifo_cfg

Overview:
Parametrised next-generation UART serialiser. It accepts bytes through a small write FIFO, so software and upstream logic can queue frames without polling busy. Data width, parity mode, stop length and oversampling ratio are configurable. It sits between the command/LED/7-seg/LCD front-end and the shared baud-tick generator; the baud generator supplies the `tick` strobe.

Parameters:
- DBITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- OVERSAMPLE, 16: ticks per start, data and parity bit; legal range 8..32.
- STOP_TICKS, 16: ticks in the stop period. 16 = 1 stop bit, 24 = 1.5, 32 = 2 at OVERSAMPLE=16. Must be >= OVERSAMPLE/2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Value 3 is treated as none.
- FIFO_DEPTH, 4: write-FIFO entries; power of two, 2..16.

Ports:
- clk_50Mhz, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- tick, input, 1: one-cycle baud-oversample strobe.
- t_en, input, 1: write strobe; pushes din into the FIFO.
- din, input, DBITS: data word to queue.
- tx, output, 1: serial line (registered, idle high).
- tx_busy, output, 1: high while a frame is in progress or the FIFO is non-empty.
- fifo_full, output, 1: FIFO holds FIFO_DEPTH entries.
- overflow, output, 1: sticky; set when a write is dropped; cleared only by reset.
- tx_done, output, 1: one-cycle pulse at the end of each stop period.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - tx=1, tx_busy=0, fifo_full=0, overflow=0, tx_done=0.
  - FIFO pointers cleared; state=IDLE; tick counter and bit counter cleared.
  - Reset mid-frame aborts the frame immediately: tx goes high with no glitch low.
- FIFO:
  - t_en with !fifo_full: din is written at the clock edge.
  - t_en with fifo_full and no pop in the same cycle: write dropped, overflow set.
  - Push and pop in the same cycle while full: push accepted; occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If FIFO non-empty: pop into the shift register, clear the tick counter, go to START.
  - tx goes low on the same edge the state becomes START.
  - Latency from the first write into an empty FIFO to tx falling: 2 clocks, independent of tick.
- START:
  - tx=0.
  - Count ticks; on the tick where count == OVERSAMPLE-1, clear the count, clear the bit counter, go to DATA.
- DATA:
  - tx = shift[0].
  - On the tick where count == OVERSAMPLE-1: shift right.
  - If bit counter == DBITS-1, go to PARITY (PARITY in {1,2}) or STOP (otherwise); else increment the bit counter.
  - Bit counter width is clog2(DBITS); DBITS=8 wraps cleanly with no extra bit.
- PARITY:
  - tx = XOR of the popped word (even mode) or its inverse (odd mode).
  - The parity value is computed at pop time from the full word, not from the shifted register.
  - Lasts OVERSAMPLE ticks, then go to STOP.
- STOP:
  - tx=1.
  - On the tick where count == STOP_TICKS-1: pulse tx_done for one cycle.
  - If the FIFO is non-empty: pop and go directly to START (back-to-back frames, no IDLE cycle, no extra idle bit).
  - Otherwise go to IDLE.
- Tick counter width is clog2(max(OVERSAMPLE, STOP_TICKS)).
- No state changes except on tick, apart from the IDLE pop.
- tick and t_en may coincide; the two are independent.
- tx_busy = (state != IDLE) || FIFO non-empty. It is combinational from registers.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- When defined: adds input port `brk` (1 bit).
  - brk sampled high in IDLE forces tx=0 and holds the FSM in IDLE. FIFO pops are suspended; writes are still accepted.
  - brk asserted mid-frame takes effect only after the current frame's STOP completes.
  - On brk deassert, tx returns high for a minimum of STOP_TICKS ticks before the next START.
  - tx_busy=1 during break.
- When undefined: no brk port; behaviour exactly as above.

Test Plan:
1. Defaults, tick every 4 clocks, write 0x55 once → tx shows 0, 1,0,1,0,1,0,1,0, 1; 160 ticks total; one tx_done pulse; tx_busy falls the cycle after STOP ends.
2. PARITY=2, write 0x07 → parity bit 1. PARITY=1, write 0x07 → parity bit 0. Frame length 176 ticks.
3. Five writes 0x11..0x15 on consecutive cycles with FIFO_DEPTH=4 → 0x11..0x14 sent back-to-back with no idle ticks between frames; 0x15 dropped; overflow=1; fifo_full high the cycle after the 4th write.
4. DBITS=7, STOP_TICKS=32, write 0x7F → 7 ones, then stop held 32 ticks; next queued frame's START begins exactly at tick 32 of stop.
5. Reset asserted at tick 50 of a frame with 2 entries queued → tx=1 asynchronously; after release tx stays high and tx_busy=0; no residual frame is sent.
6. UART_TX_BREAK_EN: brk high for 100 ticks while idle, 0x3C queued → tx low for 100 ticks, then high for 16 ticks, then the 0x3C frame.

Source files
------------

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg
// ----------------
// UART serialiser fed by a small write FIFO. Frames are start bit, DBITS data
// bits (LSB first), optional parity bit and a stop period measured in ticks.
// All bit timing is derived from the external one-cycle `tick` strobe.
//
// Optional feature: define UART_TX_BREAK_EN to add the `brk` input, which
// holds the line low while idle and then enforces a STOP_TICKS recovery
// period of idle-high before the next frame.
//
// Ports:
//   clk_50Mhz  in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick       in   baud-oversample strobe (one clock wide)
//   t_en       in   write strobe, pushes din into the FIFO
//   din        in   data word [DBITS-1:0]
//   brk        in   line break request (UART_TX_BREAK_EN builds only)
//   tx         out  serial line, registered, idle high
//   tx_busy    out  frame in progress, FIFO non-empty or break active
//   fifo_full  out  FIFO holds FIFO_DEPTH entries
//   overflow   out  sticky: a write was dropped because the FIFO was full
//   tx_done    out  one-cycle pulse at the end of each stop period
module uart_tx_fifo_cfg #(
  parameter int DBITS      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_50Mhz,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             t_en,
  input  logic [DBITS-1:0] din,
`ifdef UART_TX_BREAK_EN
  input  logic             brk,
`endif
  output logic             tx,
  output logic             tx_busy,
  output logic             fifo_full,
  output logic             overflow,
  output logic             tx_done
);

  localparam int CNT_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(DBITS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);

  localparam logic [CNT_W-1:0] OS_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DBITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic             tx_q;
  logic             done_q;
  logic             ovf_q;
  logic             hold_q;
  logic [DBITS-1:0] shift_q;
  logic             par_q;

  logic [DBITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level;

  logic             empty, full;
  logic             push, pop, drop;
  logic             os_end, stop_end, hold_end;
  logic             brk_w;
  logic [DBITS-1:0] pop_word;

`ifdef UART_TX_BREAK_EN
  assign brk_w = brk;
`else
  assign brk_w = 1'b0;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == DEPTH_C);
  assign pop_word = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign os_end   = tick && (cnt_q == OS_LAST);
  assign stop_end = tick && (cnt_q == STOP_LAST);
  // Break recovery reuses the tick counter to time STOP_TICKS of idle-high.
  assign hold_end = hold_q && !brk_w && stop_end;

  // Pops happen only from IDLE or at the final stop tick (back-to-back frames).
  always_comb begin
    pop = 1'b0;
    case (state_q)
      ST_IDLE: pop = !empty && !brk_w && (!hold_q || hold_end);
      ST_STOP: pop = !empty && !brk_w && stop_end;
      default: pop = 1'b0;
    endcase
  end

  // A pop in the same cycle frees a slot, so a write into a full FIFO survives.
  assign push     = t_en && (!full || pop);
  assign drop     = t_en && full && !pop;
  assign wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
  assign rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_q | drop;
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end
  end

  // Parity is taken from the whole word at pop time, before any shifting.
  always_ff @(posedge clk_50Mhz) begin
    if (pop) begin
      shift_q <= pop_word;
      par_q   <= (^pop_word) ^ PAR_ODD;
    end else if ((state_q == ST_DATA) && os_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
          end else if (brk_w) begin
            tx_q   <= 1'b0;
            hold_q <= 1'b1;
            cnt_q  <= '0;
          end else if (hold_q) begin
            tx_q <= 1'b1;
            if (hold_end) begin
              hold_q <= 1'b0;
              cnt_q  <= '0;
            end else if (tick) begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            tx_q <= 1'b1;
          end
        end

        ST_START: begin
          if (os_end) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else if (tick) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        // tx is registered, so on each bit boundary it takes the bit that
        // the shift register is about to expose (shift_q[1]).
        ST_DATA: begin
          if (os_end) begin
            cnt_q <= '0;
            if (bit_q == BIT_LAST) begin
              if (PAR_EN) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + BIT_ONE;
              tx_q  <= shift_q[1];
            end
          end else if (tick) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_PARITY: begin
          if (os_end) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
          end else if (tick) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_STOP: begin
          if (stop_end) begin
            done_q <= 1'b1;
            cnt_q  <= '0;
            if (pop) begin
              state_q <= ST_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else if (tick) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign overflow  = ovf_q;
  assign fifo_full = full;
  assign tx_busy   = (state_q != ST_IDLE) || !empty || hold_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Testbench for uart_tx_fifo_cfg: four instances cover the default 8N1 build,
// even and odd parity, and a 7-bit / 2-stop-bit configuration.
module tb_uart_tx_fifo_cfg;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [1:0] phase;
  int         tick_n = 0;
  int         done_cnt_a = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic       en_a, en_p, en_7;
  logic [7:0] din_a, din_p;
  logic [6:0] din_7;
`ifdef UART_TX_BREAK_EN
  logic       brk;
  logic       brk_off;
`endif

  logic tx_a,  busy_a,  full_a,  ovf_a,  done_a;
  logic tx_pe, busy_pe, full_pe, ovf_pe, done_pe;
  logic tx_po, busy_po, full_po, ovf_po, done_po;
  logic tx_d7, busy_d7, full_d7, ovf_d7, done_d7;

  uart_tx_fifo_cfg u_dut (
    .clk_50Mhz(clk), .rst_n(rst_n), .tick(tick), .t_en(en_a), .din(din_a),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .tx(tx_a), .tx_busy(busy_a), .fifo_full(full_a), .overflow(ovf_a), .tx_done(done_a)
  );

  uart_tx_fifo_cfg #(.PARITY(2)) u_pe (
    .clk_50Mhz(clk), .rst_n(rst_n), .tick(tick), .t_en(en_p), .din(din_p),
`ifdef UART_TX_BREAK_EN
    .brk(brk_off),
`endif
    .tx(tx_pe), .tx_busy(busy_pe), .fifo_full(full_pe), .overflow(ovf_pe), .tx_done(done_pe)
  );

  uart_tx_fifo_cfg #(.PARITY(1)) u_po (
    .clk_50Mhz(clk), .rst_n(rst_n), .tick(tick), .t_en(en_p), .din(din_p),
`ifdef UART_TX_BREAK_EN
    .brk(brk_off),
`endif
    .tx(tx_po), .tx_busy(busy_po), .fifo_full(full_po), .overflow(ovf_po), .tx_done(done_po)
  );

  uart_tx_fifo_cfg #(.DBITS(7), .STOP_TICKS(32)) u_d7 (
    .clk_50Mhz(clk), .rst_n(rst_n), .tick(tick), .t_en(en_7), .din(din_7),
`ifdef UART_TX_BREAK_EN
    .brk(brk_off),
`endif
    .tx(tx_d7), .tx_busy(busy_d7), .fifo_full(full_d7), .overflow(ovf_d7), .tx_done(done_d7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4 clocks, driven on the falling edge.
  initial begin
    tick  = 1'b0;
    phase = 2'd0;
    forever begin
      @(negedge clk);
      tick  = (phase == 2'd3);
      phase = phase + 2'd1;
    end
  end

  always @(posedge clk) if (tick) tick_n <= tick_n + 1;
  always @(negedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_pe;
      2:       return tx_po;
      default: return tx_d7;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_pe;
      2:       return busy_po;
      default: return busy_d7;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_pe;
      2:       return done_po;
      default: return done_d7;
    endcase
  endfunction

  task automatic wait_tick_at(input int target);
    int guard;
    guard = 0;
    while (tick_n < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("tick_sync", tick_n, target);
  endtask

  // base = tick count seen right after tx fell for the start bit.
  task automatic check_frame(input string tag, input int sel, input int base,
                             input logic [8:0] data, input int nb, input int par_bit,
                             input int stop_t, input bit next_frame);
    int k;
    int len;
    wait_tick_at(base + 8);
    chk({tag, "_start"}, get_tx(sel), 0);
    for (int i = 0; i < nb; i++) begin
      wait_tick_at(base + 16 * (i + 1) + 8);
      chk($sformatf("%s_d%0d", tag, i), get_tx(sel), data[i]);
    end
    k = nb + 1;
    if (par_bit >= 0) begin
      wait_tick_at(base + 16 * k + 8);
      chk({tag, "_parity"}, get_tx(sel), par_bit[0]);
      k++;
    end
    len = 16 * k + stop_t;
    wait_tick_at(base + 16 * k + 8);
    chk({tag, "_stop_mid"}, get_tx(sel), 1);
    wait_tick_at(base + len - 1);
    chk({tag, "_stop_last"}, get_tx(sel), 1);
    chk({tag, "_busy_in_stop"}, get_busy(sel), 1);
    chk({tag, "_done_early"}, get_done(sel), 0);
    wait_tick_at(base + len);
    chk({tag, "_done"}, get_done(sel), 1);
    chk({tag, "_after_stop_tx"}, get_tx(sel), next_frame ? 0 : 1);
  endtask

  initial begin
    int base;
    int d0;
    int lows;
    int busy_seen;
    rst_n = 1'b0;
    en_a = 1'b0; en_p = 1'b0; en_7 = 1'b0;
    din_a = '0; din_p = '0; din_7 = '0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
    brk_off = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tx_others", {tx_pe, tx_po, tx_d7}, 3'b111);
    chk("rst_flags_others", {busy_pe, full_pe, ovf_pe, done_pe, busy_po, full_po,
                             ovf_po, done_po, busy_d7, full_d7, ovf_d7, done_d7}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0x55 frame, 2-clock write-to-start latency
    en_a = 1'b1; din_a = 8'h55;
    @(negedge clk);
    en_a = 1'b0;
    chk("lat_e1_tx", tx_a, 1);
    chk("lat_e1_busy", busy_a, 1);
    @(negedge clk);
    chk("lat_e2_tx", tx_a, 0);
    base = tick_n;
    d0 = done_cnt_a;
    check_frame("f55", 0, base, 9'h055, 8, -1, 16, 1'b0);
    chk("f55_busy_end", busy_a, 0);
    @(negedge clk);
    chk("f55_done_once", done_cnt_a - d0, 1);
    chk("f55_done_clr", done_a, 0);

    // Parity: 0x07 has three ones
    en_p = 1'b1; din_p = 8'h07;
    @(negedge clk);
    en_p = 1'b0;
    @(negedge clk);
    chk("par_start_pe", tx_pe, 0);
    chk("par_start_po", tx_po, 0);
    base = tick_n;
    fork
      check_frame("pe07", 1, base, 9'h007, 8, 1, 16, 1'b0);
      check_frame("po07", 2, base, 9'h007, 8, 0, 16, 1'b0);
    join

    // FIFO fill and overflow while a frame is already on the line
    en_a = 1'b1; din_a = 8'h10;
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    chk("f10_start", tx_a, 0);
    base = tick_n;
    for (int i = 0; i < 5; i++) begin
      en_a = 1'b1;
      din_a = 8'h11 + 8'(i);
      @(negedge clk);
      if (i == 2) chk("full_after_3", full_a, 0);
      if (i == 3) chk("full_after_4", full_a, 1);
    end
    en_a = 1'b0;
    chk("ovf_set", ovf_a, 1);
    chk("full_hold", full_a, 1);
    check_frame("f10", 0, base, 9'h010, 8, -1, 16, 1'b1);
    check_frame("f11", 0, base + 160, 9'h011, 8, -1, 16, 1'b1);
    check_frame("f12", 0, base + 320, 9'h012, 8, -1, 16, 1'b1);
    check_frame("f13", 0, base + 480, 9'h013, 8, -1, 16, 1'b1);
    check_frame("f14", 0, base + 640, 9'h014, 8, -1, 16, 1'b0);
    chk("f14_busy_end", busy_a, 0);
    chk("ovf_sticky", ovf_a, 1);
    wait_tick_at(base + 800 + 40);
    chk("no_f15_tx", tx_a, 1);
    chk("no_f15_busy", busy_a, 0);

    // 7 data bits, 2 stop bits, second frame queued
    en_7 = 1'b1; din_7 = 7'h7F;
    @(negedge clk);
    din_7 = 7'h2A;
    @(negedge clk);
    en_7 = 1'b0;
    chk("d7_start", tx_d7, 0);
    base = tick_n;
    check_frame("d7_7f", 3, base, 9'h07F, 7, -1, 32, 1'b1);
    check_frame("d7_2a", 3, base + 160, 9'h02A, 7, -1, 32, 1'b0);

    // Reset in the middle of a frame with two entries queued
    en_a = 1'b1; din_a = 8'h00;
    @(negedge clk);
    din_a = 8'h01;
    @(negedge clk);
    chk("rstmid_start", tx_a, 0);
    base = tick_n;
    din_a = 8'h02;
    @(negedge clk);
    en_a = 1'b0;
    wait_tick_at(base + 50);
    chk("rstmid_pre_tx", tx_a, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_tx", tx_a, 1);
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_full", full_a, 0);
    chk("rstmid_ovf", ovf_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    busy_seen = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (tx_a == 1'b0) lows++;
      if (busy_a == 1'b1) busy_seen++;
    end
    chk("rstmid_no_residual_low", lows, 0);
    chk("rstmid_no_busy", busy_seen, 0);

`ifdef UART_TX_BREAK_EN
    // Break while idle with 0x3C queued
    brk = 1'b1;
    @(negedge clk);
    en_a = 1'b1; din_a = 8'h3C;
    @(negedge clk);
    en_a = 1'b0;
    chk("brk_tx_low", tx_a, 0);
    chk("brk_busy", busy_a, 1);
    base = tick_n;
    wait_tick_at(base + 50);
    chk("brk_mid_tx", tx_a, 0);
    wait_tick_at(base + 100);
    chk("brk_end_tx", tx_a, 0);
    brk = 1'b0;
    base = tick_n;
    wait_tick_at(base + 8);
    chk("brk_rec_mid", tx_a, 1);
    chk("brk_rec_busy", busy_a, 1);
    wait_tick_at(base + 15);
    chk("brk_rec_last", tx_a, 1);
    wait_tick_at(base + 16);
    chk("brk_frame_start", tx_a, 0);
    check_frame("f3c", 0, base + 16, 9'h03C, 8, -1, 16, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
